// File: rtl/syncfifo_ctl.sv
// -----------------------------------------------------------------------------
// syncfifo_ctl
//
// Single-clock FIFO with registered status. It tracks occupancy, compares the
// count against programmable thresholds, reports rejected requests, and can
// optionally present the head word without a read (first-word-fall-through).
//
// Parameters
//   WIDTH          data word width in bits (>= 1)
//   DEPTH          storage words, power of two, >= 4
//   PROG_FULL_TH   prog_full  when data_count >= PROG_FULL_TH  (1..DEPTH)
//   PROG_EMPTY_TH  prog_empty when data_count <= PROG_EMPTY_TH (0..DEPTH-1)
//   FWFT           0: data_out loads one cycle after rd_en
//                  1: head word is shown on data_out while empty == 0
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       write request, data_in is sampled with it
//   data_in     write data
//   rd_en       read request (in FWFT mode: pop the presented word)
//   data_out    read data, don't-care while empty
//   full        data_count == DEPTH
//   empty       no word available to read
//   prog_full   data_count >= PROG_FULL_TH
//   prog_empty  data_count <= PROG_EMPTY_TH
//   data_count  stored words, 0..DEPTH
//   overflow    high for the cycle after a rejected write
//   underflow   high for the cycle after a rejected read
//
// All outputs come straight from flops. There is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module syncfifo_ctl #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 512,
  parameter int PROG_FULL_TH  = DEPTH - 4,
  parameter int PROG_EMPTY_TH = 4,
  parameter bit FWFT          = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] CNT_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] CNT_PF   = PW'(PROG_FULL_TH);
  localparam logic [PW-1:0] CNT_PE   = PW'(PROG_EMPTY_TH);

  // Storage. It is deliberately not reset, so it can map onto RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit. The low AW bits are the address, and
  // they wrap from DEPTH-1 to 0 on their own.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [PW-1:0] cnt_nxt;
  logic [AW-1:0] wr_addr, rd_addr;

  logic wr_acc;   // write accepted this cycle
  logic rd_acc;   // user read accepted this cycle
  logic mem_pop;  // a word leaves the storage array this cycle

  // full and empty are registered. Acceptance therefore depends only on state
  // plus the request. If the FIFO is full and both requests arrive, the read
  // wins and the write is dropped. If the FIFO is empty and both arrive, the
  // write wins and the read is dropped.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign wr_addr    = wr_ptr[AW-1:0];
  assign rd_addr    = rd_ptr[AW-1:0];
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_acc};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, mem_pop};

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= data_in;
  end

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Count, threshold flags and error pulses.
  // Every one is taken from the next-state count, so each updates on the same
  // edge that changes the occupancy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_count <= '0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_count <= cnt_nxt;
      full       <= (cnt_nxt == CNT_FULL);
      prog_full  <= (cnt_nxt >= CNT_PF);
      prog_empty <= (cnt_nxt <= CNT_PE);
      // A rejected request pulses for one cycle. Back-to-back rejects keep the
      // flag high.
      overflow   <= wr_en & ~wr_acc;
      underflow  <= rd_en & ~rd_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  generate
    if (FWFT) begin : g_fwft
      // data_out is the head register, and its valid flag is ~empty. Whenever
      // the register is free or being popped, it pulls the next word from the
      // array. As a result, a word written into an empty FIFO reaches data_out
      // one edge after the edge that wrote it.
      logic out_vld;
      logic out_vld_nxt;
      logic refill;

      assign out_vld     = ~empty;
      assign refill      = (~out_vld | rd_acc) & (wr_ptr != rd_ptr);
      assign out_vld_nxt = refill | (out_vld & ~rd_acc);
      assign mem_pop     = refill;

      // The occupancy includes the word held in the head register.
      assign cnt_nxt = (wr_ptr_nxt - rd_ptr_nxt) + {{AW{1'b0}}, out_vld_nxt};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
          empty    <= 1'b1;
        end else begin
          empty <= ~out_vld_nxt;
          if (refill) data_out <= mem[rd_addr];
        end
      end
    end else begin : g_std
      // Standard mode: an accepted read loads data_out from the array. Otherwise
      // data_out keeps its last value.
      assign mem_pop = rd_acc;
      assign cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out <= '0;
          empty    <= 1'b1;
        end else begin
          empty <= (cnt_nxt == '0);
          if (rd_acc) data_out <= mem[rd_addr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_syncfifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_syncfifo_ctl
//
// Two instances run side by side, both with DEPTH=16, PROG_FULL_TH=12 and
// PROG_EMPTY_TH=4:
//   u0  standard read mode
//   u1  first-word-fall-through mode
//
// The stimulus task drives one cycle of requests. It advances a queue-based
// reference model of the FIFO contents and pushes the expected status and
// read data into scoreboard queues. A monitor on the falling edge pops those
// queues and compares whenever the DUT shows a read handshake or a status
// update is due.
// -----------------------------------------------------------------------------
module tb_syncfifo_ctl;

  localparam int D = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic [7:0] dout0, dout1;
  logic       full0, empty0, pf0, pe0, ovf0, unf0;
  logic       full1, empty1, pf1, pe1, ovf1, unf1;
  logic [4:0] cnt0, cnt1;

  syncfifo_ctl #(.WIDTH(8), .DEPTH(D), .PROG_FULL_TH(12), .PROG_EMPTY_TH(4), .FWFT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
    .data_out(dout0), .full(full0), .empty(empty0), .prog_full(pf0), .prog_empty(pe0),
    .data_count(cnt0), .overflow(ovf0), .underflow(unf0));

  syncfifo_ctl #(.WIDTH(8), .DEPTH(D), .PROG_FULL_TH(12), .PROG_EMPTY_TH(4), .FWFT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
    .data_out(dout1), .full(full1), .empty(empty1), .prog_full(pf1), .prog_empty(pe1),
    .data_count(cnt1), .overflow(ovf1), .underflow(unf1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tag = value of cyc after the edge that this expectation describes
  typedef struct {
    int         tag;
    logic [4:0] cnt;
    logic [5:0] flg;   // {full, empty, prog_full, prog_empty, overflow, underflow}
    logic [7:0] dout;
  } st_t;

  st_t        st0_q[$], st1_q[$];
  logic [7:0] d0_q[$], d1_q[$];     // expected read data, in order
  logic [7:0] m0[$], m1[$];         // model contents (head first)
  bit         vis1   = 1'b0;        // model: FWFT head word visible on data_out
  logic [7:0] mdout0 = '0;          // model: standard-mode data_out hold value

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [5:0] flags(input int n, input bit e, input bit o, input bit u);
    return {n == D, e, n >= 12, n <= 4, o, u};
  endfunction

  // One clock of stimulus for both DUTs, plus the model update for the edge
  // that follows.
  task automatic step(input bit w_0, input bit r_0, input logic [7:0] dd0,
                      input bit w_1, input bit r_1, input logic [7:0] dd1);
    bit  rok, wok;
    int  memc;
    st_t s;
    @(posedge clk); #2;
    wr0 = w_0; rd0 = r_0; din0 = dd0;
    wr1 = w_1; rd1 = r_1; din1 = dd1;

    // Standard mode: a read needs a stored word and a write needs a free slot.
    // Both decisions use the occupancy before the edge.
    rok = r_0 && (m0.size() > 0);
    wok = w_0 && (m0.size() < D);
    if (rok) begin
      mdout0 = m0.pop_front();
      d0_q.push_back(mdout0);
    end
    if (wok) m0.push_back(dd0);
    s.tag  = cyc + 1;
    s.cnt  = 5'(m0.size());
    s.flg  = flags(m0.size(), m0.size() == 0, w_0 && !wok, r_0 && !rok);
    s.dout = mdout0;
    st0_q.push_back(s);

    // FWFT: a pop needs a visible head. Afterwards the head is visible if it
    // stayed unpopped, or if a word was already waiting behind it before this
    // edge.
    rok  = r_1 && vis1;
    wok  = w_1 && (m1.size() < D);
    memc = m1.size() - (vis1 ? 1 : 0);
    if (rok) d1_q.push_back(m1.pop_front());
    if (wok) m1.push_back(dd1);
    vis1   = (vis1 && !rok) || (memc > 0);
    s.tag  = cyc + 1;
    s.cnt  = 5'(m1.size());
    s.flg  = flags(m1.size(), !vis1, w_1 && !wok, r_1 && !rok);
    s.dout = '0;
    st1_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_vals();
    chk("reset dout0", 32'(dout0), 32'h0);
    chk("reset count0", 32'(cnt0), 32'h0);
    chk("reset flags0", 32'({full0, empty0, pf0, pe0, ovf0, unf0}), 32'(6'b010100));
    chk("reset dout1", 32'(dout1), 32'h0);
    chk("reset count1", 32'(cnt1), 32'h0);
    chk("reset flags1", 32'({full1, empty1, pf1, pe1, ovf1, unf1}), 32'(6'b010100));
  endtask

  // Assert reset mid-cycle, check that the outputs clear without waiting for an
  // edge, then release.
  task automatic reset_midop();
    @(posedge clk); #3;
    rst_n = 1'b0;
    wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
    #1;
    chk_reset_vals();
    st0_q.delete(); st1_q.delete(); d0_q.delete(); d1_q.delete();
    m0.delete(); m1.delete();
    vis1   = 1'b0;
    mdout0 = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic rand_phase(input int blocks);
    int p0w, p0r, p1w, p1r;
    for (int b = 0; b < blocks; b++) begin
      p0w = $urandom_range(10, 90); p0r = $urandom_range(10, 90);
      p1w = $urandom_range(10, 90); p1r = $urandom_range(10, 90);
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 99) < p0w, $urandom_range(0, 99) < p0r, 8'($urandom_range(0, 255)),
             $urandom_range(0, 99) < p1w, $urandom_range(0, 99) < p1r, 8'($urandom_range(0, 255)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    st_t s;
    bit  pend0;
    pend0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend0 = 1'b0;
      end else begin
        while (st0_q.size() > 0 && st0_q[0].tag <= cyc) begin
          s = st0_q.pop_front();
          chk("count0", 32'(cnt0), 32'(s.cnt));
          chk("flags0", 32'({full0, empty0, pf0, pe0, ovf0, unf0}), 32'(s.flg));
          chk("dout0 hold", 32'(dout0), 32'(s.dout));
        end
        while (st1_q.size() > 0 && st1_q[0].tag <= cyc) begin
          s = st1_q.pop_front();
          chk("count1", 32'(cnt1), 32'(s.cnt));
          chk("flags1", 32'({full1, empty1, pf1, pe1, ovf1, unf1}), 32'(s.flg));
        end
        // Standard mode: the word arrives on data_out one edge after the handshake.
        if (pend0) begin
          if (d0_q.size() == 0) fail_now("read data0 unexpected read");
          else chk("read data0", 32'(dout0), 32'(d0_q.pop_front()));
        end
        pend0 = rd0 && !empty0;
        // FWFT: the word being popped is the one shown right now.
        if (rd1 && !empty1) begin
          if (d1_q.size() == 0) fail_now("pop data1 unexpected pop");
          else chk("pop data1", 32'(dout1), 32'(d1_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    fail_now("watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stim
    repeat (2) @(posedge clk);
    #3;
    chk_reset_vals();
    rst_n = 1'b1;
    idle(2);

    // Standard mode: fill past full. The 17th write overflows.
    for (int i = 0; i <= 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00);
    // Read 17 times. The last read underflows and data_out holds 15.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);

    // Hold at count 5, then stream reads and writes together past the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(100 + i), 1'b1, 1'b0, 8'(150 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 8'(128 + i));

    // Fill to full. A write alone overflows. Write plus read pops and drops
    // the write.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(60 + i), 1'b1, 1'b0, 8'(70 + i));
    step(1'b1, 1'b0, 8'hE0, 1'b1, 1'b0, 8'hE1);
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 8'hEF);

    // Drain both, ending with underflow.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);

    // FWFT: a single word falls through without rd_en, then one pop empties it.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    idle(1);
    // Empty with write and read together: the write is kept and the read rejected.
    step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C);
    idle(2);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
    idle(1);

    rand_phase(8);

    // Leave data in both, then reset mid-operation.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h11 * (i + 1)), 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    idle(1);
    reset_midop();
    idle(2);

    rand_phase(2);

    // Flush everything that is still queued.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);
    idle(2);
    repeat (2) @(negedge clk);
    #1;
    chk("drain read data0", 32'(d0_q.size()), 32'd0);
    chk("drain pop data1", 32'(d1_q.size()), 32'd0);
    chk("drain status", 32'(st0_q.size() + st1_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
